// File: rtl/pwm_duty_scheduler_if.sv
// Bus between the register decode (master) and the duty scheduler (slave).
//
// Handshake: commit_req is a single-cycle request with no ready; the
// scheduler always accepts it (starting a commit from idle, or merging it
// into a one-deep pending flag while busy). busy is high while a commit waits
// for or runs its load window, and commit_done pulses for one cycle as the
// commit finishes. duty_load is a one-cycle strobe; duty_data is valid with
// it and holds until the next strobe.
interface pwm_duty_scheduler_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [WIDTH-1:0]    counter_value;
   logic                wr_en;
   logic [CW-1:0]       wr_chan;
   logic [WIDTH-1:0]    wr_data;
   logic                commit_req;
   logic [WIDTH-1:0]    duty_data;
   logic [CHANNELS-1:0] duty_load;
   logic                busy;
   logic                commit_done;
   logic                late;
   logic [CHANNELS-1:0] dirty;
   logic [1:0]          state_dbg;

   modport master (
      output counter_value, wr_en, wr_chan, wr_data, commit_req,
      input  duty_data, duty_load, busy, commit_done, late, dirty, state_dbg
   );

   modport slave (
      input  counter_value, wr_en, wr_chan, wr_data, commit_req,
      output duty_data, duty_load, busy, commit_done, late, dirty, state_dbg
   );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Applies shadowed duty values to a bank of lockstep countdown PWM channels,
// one channel per cycle, only inside the low window right after rollover.
module pwm_duty_scheduler #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   parameter int START    = 65535
) (
   input  logic                  sysclk,
   input  logic                  sysreset,
   pwm_duty_scheduler_if.slave   bus
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_shadow [CHANNELS];
   logic [CHANNELS-1:0] r_dirty;
   logic [CHANNELS-1:0] r_latch;
   logic [WIDTH-1:0]    r_duty_data;
   logic [CHANNELS-1:0] r_duty_load;
   logic                r_busy;
   logic                r_done;
   logic                r_late;
   logic                r_pending;
   logic                r_prev_start;

   logic                w_at_start;
   logic                w_rollover;
   logic                w_wr;
   logic [CHANNELS-1:0] w_sel_src;
   logic                w_sel_valid;
   logic [CW-1:0]       w_sel_idx;
   logic [CHANNELS-1:0] w_sel_onehot;
   logic                w_issue;
   logic                w_relatch;
   logic                w_set_late;
   logic [CHANNELS-1:0] w_dirty_nxt;

   // A rollover is the first cycle of a START level; prev_start resets high so
   // a START level already present at reset does not count.
   assign w_at_start = (bus.counter_value == WIDTH'(START));
   assign w_rollover = w_at_start && !r_prev_start;
   assign w_wr       = bus.wr_en && (int'(bus.wr_chan) < CHANNELS);

   // Pick the lowest-index candidate: all dirty channels when a window opens,
   // otherwise only what remains of the set latched for this commit.
   always_comb begin
      w_sel_src   = (r_state == S_ARM) ? r_dirty : r_latch;
      w_sel_valid = 1'b0;
      w_sel_idx   = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (w_sel_src[i]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = CW'(i);
         end
      end
      w_sel_onehot = CHANNELS'(1) << w_sel_idx;
   end

   // State register.
   always_ff @(posedge sysclk) begin
      if (sysreset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; an empty commit skips LOAD so it finishes at R+1.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (bus.commit_req) w_state_nxt = S_ARM;
         S_ARM: begin
            if (w_rollover) w_state_nxt = w_sel_valid ? S_LOAD : S_DONE;
         end
         S_LOAD: begin
            if (!w_sel_valid)     w_state_nxt = S_DONE;
            else if (!w_at_start) w_state_nxt = S_ARM;
         end
         S_DONE: w_state_nxt = (r_pending || bus.commit_req) ? S_ARM : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode: whether a load is issued this cycle and whether the
   // window closed on a partially applied commit.
   always_comb begin
      w_issue    = 1'b0;
      w_relatch  = 1'b0;
      w_set_late = 1'b0;
      case (r_state)
         S_ARM: begin
            if (w_rollover && w_sel_valid) begin
               w_issue   = 1'b1;
               w_relatch = 1'b1;
            end
         end
         S_LOAD: begin
            if (w_sel_valid) begin
               if (w_at_start) w_issue    = 1'b1;
               else            w_set_late = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Dirty flags: a load clears its channel, a same-cycle write re-sets it.
   always_comb begin
      w_dirty_nxt = r_dirty;
      if (w_issue) w_dirty_nxt = w_dirty_nxt & ~w_sel_onehot;
      if (w_wr)    w_dirty_nxt[bus.wr_chan] = 1'b1;
   end

   // Datapath and registered outputs.
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= '0;
         r_dirty      <= '0;
         r_latch      <= '0;
         r_duty_data  <= '0;
         r_duty_load  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_late       <= 1'b0;
         r_pending    <= 1'b0;
         r_prev_start <= 1'b1;
      end else begin
         r_prev_start <= w_at_start;
         r_dirty      <= w_dirty_nxt;
         if (w_wr) r_shadow[bus.wr_chan] <= bus.wr_data;

         if (w_relatch)    r_latch <= r_dirty & ~w_sel_onehot;
         else if (w_issue) r_latch <= r_latch & ~w_sel_onehot;

         r_duty_load <= w_issue ? w_sel_onehot : '0;
         if (w_issue) r_duty_data <= r_shadow[w_sel_idx];

         r_busy <= (w_state_nxt == S_ARM) || (w_state_nxt == S_LOAD);
         r_done <= (w_state_nxt == S_DONE);

         if (r_state == S_IDLE && bus.commit_req) r_late <= 1'b0;
         else if (w_set_late)                     r_late <= 1'b1;

         // A commit arriving in DONE goes straight to ARM, so DONE consumes it.
         if (r_state == S_DONE) r_pending <= 1'b0;
         else if (bus.commit_req && (r_state == S_ARM || r_state == S_LOAD))
            r_pending <= 1'b1;
      end
   end

   assign bus.duty_data   = r_duty_data;
   assign bus.duty_load   = r_duty_load;
   assign bus.busy        = r_busy;
   assign bus.commit_done = r_done;
   assign bus.late        = r_late;
   assign bus.dirty       = r_dirty;
   assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler: hand-computed expectations per cycle.
module tb_pwm_duty_scheduler;
   localparam int CHANNELS = 4;
   localparam int WIDTH    = 16;
   localparam int START    = 65535;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   pwm_duty_scheduler_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) u_bus ();

   pwm_duty_scheduler #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .START(START)) dut (
      .sysclk   (clk),
      .sysreset (rst),
      .bus      (u_bus)
   );

   // Clock and reset defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input int ch, input logic [WIDTH-1:0] d);
      u_bus.wr_en   = 1'b1;
      u_bus.wr_chan = 2'(ch);
      u_bus.wr_data = d;
      tick();
      u_bus.wr_en   = 1'b0;
   endtask

   task automatic commit();
      u_bus.commit_req = 1'b1;
      tick();
      u_bus.commit_req = 1'b0;
   endtask

   task automatic do_reset(input logic [WIDTH-1:0] cv);
      rst = 1'b1;
      u_bus.counter_value = cv;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      u_bus.counter_value = 16'd100;
      u_bus.wr_en      = 1'b0;
      u_bus.wr_chan    = '0;
      u_bus.wr_data    = '0;
      u_bus.commit_req = 1'b0;

      // Reset values.
      do_reset(16'd100);
      chk("rst_duty_data", u_bus.duty_data, 0);
      chk("rst_duty_load", u_bus.duty_load, 0);
      chk("rst_busy", u_bus.busy, 0);
      chk("rst_done", u_bus.commit_done, 0);
      chk("rst_late", u_bus.late, 0);
      chk("rst_dirty", u_bus.dirty, 0);
      chk("rst_state", u_bus.state_dbg, 0);

      // Basic commit: ch1=0x1000, ch3=0x0000.
      wr(1, 16'h1000);
      chk("basic_dirty1", u_bus.dirty, 4'b0010);
      wr(3, 16'h0000);
      chk("basic_dirty2", u_bus.dirty, 4'b1010);
      commit();
      chk("basic_busy", u_bus.busy, 1);
      chk("basic_arm_noload", u_bus.duty_load, 0);
      u_bus.counter_value = 16'(START);          // cycle R
      tick();                                    // R+1
      chk("basic_load1", u_bus.duty_load, 4'b0010);
      chk("basic_data1", u_bus.duty_data, 16'h1000);
      tick();                                    // R+2
      chk("basic_load2", u_bus.duty_load, 4'b1000);
      chk("basic_data2", u_bus.duty_data, 16'h0000);
      chk("basic_busy_r2", u_bus.busy, 1);
      tick();                                    // R+3
      chk("basic_load_off", u_bus.duty_load, 0);
      chk("basic_done", u_bus.commit_done, 1);
      chk("basic_busy_low", u_bus.busy, 0);
      chk("basic_dirty0", u_bus.dirty, 0);
      tick();
      chk("basic_done_pulse", u_bus.commit_done, 0);
      chk("basic_idle", u_bus.state_dbg, 0);

      // No false rollover when START is held through reset.
      do_reset(16'(START));
      wr(0, 16'hABCD);
      commit();
      for (int i = 0; i < 3; i++) begin
         chk("nofalse_noload", u_bus.duty_load, 0);
         chk("nofalse_busy", u_bus.busy, 1);
         tick();
      end
      u_bus.counter_value = 16'd5;
      tick();
      chk("nofalse_leave", u_bus.duty_load, 0);
      u_bus.counter_value = 16'(START);          // R
      tick();
      chk("nofalse_load", u_bus.duty_load, 4'b0001);
      chk("nofalse_data", u_bus.duty_data, 16'hABCD);
      tick();
      chk("nofalse_done", u_bus.commit_done, 1);

      // Window closes after the second of four loads.
      u_bus.counter_value = 16'd100;
      tick();
      wr(0, 16'h0011);
      wr(1, 16'h0022);
      wr(2, 16'h0033);
      wr(3, 16'h0044);
      commit();
      u_bus.counter_value = 16'(START);          // R
      tick();                                    // R+1
      chk("late_load1", u_bus.duty_load, 4'b0001);
      chk("late_data1", u_bus.duty_data, 16'h0011);
      tick();                                    // R+2
      chk("late_load2", u_bus.duty_load, 4'b0010);
      chk("late_data2", u_bus.duty_data, 16'h0022);
      u_bus.counter_value = 16'd200;
      tick();                                    // R+3
      chk("late_stop", u_bus.duty_load, 0);
      chk("late_flag", u_bus.late, 1);
      chk("late_busy", u_bus.busy, 1);
      chk("late_state_arm", u_bus.state_dbg, 1);
      chk("late_dirty", u_bus.dirty, 4'b1100);
      tick();
      chk("late_wait", u_bus.duty_load, 0);
      u_bus.counter_value = 16'(START);          // R2
      tick();
      chk("late_load3", u_bus.duty_load, 4'b0100);
      chk("late_data3", u_bus.duty_data, 16'h0033);
      tick();
      chk("late_load4", u_bus.duty_load, 4'b1000);
      chk("late_data4", u_bus.duty_data, 16'h0044);
      tick();
      chk("late_done", u_bus.commit_done, 1);
      chk("late_sticky", u_bus.late, 1);
      chk("late_dirty0", u_bus.dirty, 0);

      // Write an already-loaded channel and commit while busy.
      u_bus.counter_value = 16'd100;
      tick();
      wr(0, 16'h0A0A);
      wr(2, 16'h0C0C);
      commit();
      chk("busy_late_cleared", u_bus.late, 0);
      u_bus.counter_value = 16'(START);          // R
      tick();                                    // R+1
      chk("busy_load1", u_bus.duty_load, 4'b0001);
      chk("busy_data1", u_bus.duty_data, 16'h0A0A);
      u_bus.wr_en = 1'b1;
      u_bus.wr_chan = 2'd0;
      u_bus.wr_data = 16'hBEEF;
      u_bus.commit_req = 1'b1;
      tick();                                    // R+2
      u_bus.wr_en = 1'b0;
      u_bus.commit_req = 1'b0;
      chk("busy_load2", u_bus.duty_load, 4'b0100);
      chk("busy_data2", u_bus.duty_data, 16'h0C0C);
      chk("busy_redirty", u_bus.dirty, 4'b0001);
      tick();                                    // R+3
      chk("busy_done", u_bus.commit_done, 1);
      chk("busy_low", u_bus.busy, 0);
      tick();                                    // R+4
      chk("busy_pending_rearm", u_bus.busy, 1);
      chk("busy_pending_state", u_bus.state_dbg, 1);
      u_bus.counter_value = 16'd100;
      tick();
      chk("busy_hold_noload", u_bus.duty_load, 0);
      u_bus.counter_value = 16'(START);
      tick();
      chk("busy_second_load", u_bus.duty_load, 4'b0001);
      chk("busy_second_data", u_bus.duty_data, 16'hBEEF);
      tick();
      chk("busy_second_done", u_bus.commit_done, 1);
      chk("busy_second_dirty", u_bus.dirty, 0);

      // Empty commit.
      u_bus.counter_value = 16'd100;
      tick();
      commit();
      chk("empty_busy", u_bus.busy, 1);
      u_bus.counter_value = 16'(START);          // R
      tick();                                    // R+1
      chk("empty_noload", u_bus.duty_load, 0);
      chk("empty_done", u_bus.commit_done, 1);
      chk("empty_busy_low", u_bus.busy, 0);
      chk("empty_data_hold", u_bus.duty_data, 16'hBEEF);
      tick();
      chk("empty_done_pulse", u_bus.commit_done, 0);

      // Write colliding with the load of the same channel.
      u_bus.counter_value = 16'd100;
      tick();
      wr(3, 16'h3333);
      commit();
      u_bus.counter_value = 16'(START);          // R
      u_bus.wr_en = 1'b1;
      u_bus.wr_chan = 2'd3;
      u_bus.wr_data = 16'h4444;
      tick();                                    // R+1
      u_bus.wr_en = 1'b0;
      chk("coll_load", u_bus.duty_load, 4'b1000);
      chk("coll_data", u_bus.duty_data, 16'h3333);
      chk("coll_dirty", u_bus.dirty, 4'b1000);
      tick();
      chk("coll_done", u_bus.commit_done, 1);
      chk("coll_dirty_kept", u_bus.dirty, 4'b1000);

      // Reset in the cycle after the first load.
      u_bus.counter_value = 16'd100;
      tick();
      wr(1, 16'h1111);
      wr(2, 16'h2222);
      commit();
      u_bus.counter_value = 16'(START);          // R
      tick();                                    // R+1
      chk("rst_mid_load1", u_bus.duty_load, 4'b1010 & 4'b0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_load", u_bus.duty_load, 0);
      chk("rst_mid_data", u_bus.duty_data, 0);
      chk("rst_mid_busy", u_bus.busy, 0);
      chk("rst_mid_dirty", u_bus.dirty, 0);
      chk("rst_mid_done", u_bus.commit_done, 0);
      chk("rst_mid_late", u_bus.late, 0);
      chk("rst_mid_state", u_bus.state_dbg, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_quiet", u_bus.duty_load, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pwm_duty_scheduler.md
# pwm_duty_scheduler

Sequencer for a bank of countdown PWM channels that share one timebase: all channels use the same counter event and reset, so their counters run in lockstep. Software writes new duty values into per-channel shadow registers, then issues a commit. The block waits for the next counter rollover and drives each changed value onto the channels' shared duty write bus, one `duty_load` strobe per cycle. Updates therefore land only in the low window right after rollover, and duty changes are glitch-free. It sits between the peripheral register decode and the PWM channel instances.

## Interface
- `CHANNELS`, 4: number of PWM channels served (1..16).
- `WIDTH`, 16: duty and counter width; must match the PWM channels.
- `START`, 65535: counter reload value; must match the PWM channels.

Ports:
- `sysclk` in 1: the single clock.
- `sysreset` in 1: reset, synchronous, active-high.
- `counter_value` in WIDTH: counter of channel 0, which stands in for all channels.
- `wr_en` in 1: shadow write strobe.
- `wr_chan` in $clog2(CHANNELS) (min 1): channel index for the write; out-of-range writes are ignored.
- `wr_data` in WIDTH: new duty value.
- `commit_req` in 1: single-cycle request to apply all dirty shadows.
- `duty_data` out WIDTH: shared `data_in` bus to all channels.
- `duty_load` out CHANNELS: one-hot (or zero) load strobes, bit k goes to channel k.
- `busy` out 1: a commit is in progress.
- `commit_done` out 1: one-cycle pulse when a commit finishes.
- `late` out 1: sticky; a commit straddled more than one rollover window.
- `dirty` out CHANNELS: per-channel "shadow not yet applied" flags.

## Operation
- **Shadow write.** `wr_en` writes `wr_data` to `shadow[wr_chan]` and sets `dirty[wr_chan]`.
- **Rollover detection.**
  - `prev_start` is a register holding (`counter_value == START`) from the prior cycle.
  - A rollover is `counter_value == START && !prev_start`.
  - `prev_start` resets to 1, so the START level present right after reset is not treated as a rollover.
- **States:**
  - IDLE: on `commit_req` go to ARM; `busy` = 1.
  - ARM: on rollover go to LOAD.
  - LOAD:
    - Each cycle, select the lowest-index channel k with `dirty[k]`.
    - Register `duty_data` = `shadow[k]` and `duty_load` = 1<<k, then clear `dirty[k]`.
    - If no dirty channel remains, go to DONE.
    - If `counter_value != START` (the window has closed) while dirty channels remain, go to ARM and set `late`.
  - DONE: pulse `commit_done` for one cycle, drop `busy`. Go to ARM if a commit is pending, else go to IDLE.
- **Dirty set frozen.** The set of channels a commit may load is latched at LOAD entry; only those channels are loaded.
  - A write during LOAD to a channel already loaded, or not in the latched set, leaves it dirty for the next commit.
  - A write to a latched, not-yet-loaded channel updates its shadow; the new value is the one loaded.
- **Commits while busy.** `commit_req` while `busy` sets a one-deep pending flag; further requests merge into it.
- **`late` flag.** Cleared by a `commit_req` accepted in IDLE.
- **Zero dirty channels.** A commit with nothing dirty still waits for a rollover, then completes with no `duty_load` pulses.
- **Simultaneous events.**
  - `wr_en` and a load of the same channel in one cycle: the write wins the shadow and `dirty` stays set.
  - `commit_req` in DONE counts as pending.
- **Reset.** Reset is synchronous and may arrive mid-operation; it aborts any commit and produces no partial load pulse afterwards.
- **Reset values:** state IDLE; `duty_data`=0, `duty_load`=0, `busy`=0, `commit_done`=0, `late`=0, `dirty`=0, all shadows 0, pending=0, `prev_start`=1.

## Timing
- All outputs are registered.
- `commit_req` at cycle t: `busy` = 1 at t+1.
- Rollover first seen at cycle R: the first `duty_load` is at R+1.
- n latched dirty channels: pulses occur at R+1..R+n on consecutive cycles, `commit_done` at R+n+1, `busy` low at R+n+1 and after.
- `duty_load` is high for exactly one cycle per load. `duty_data` is valid in the same cycle and holds its value until the next load.
- Window check: the load issued at cycle c requires `counter_value == START` sampled at c-1.
- `wr_en` at cycle t: `dirty` visible at t+1.

## Test plan
- **Basic commit.**
  - Stimulus: reset; write ch1=0x1000 and ch3=0x0000; commit; present a rollover at R.
  - Required: `duty_load`=0b0010 with 0x1000 at R+1, 0b1000 with 0x0000 at R+2, `commit_done` at R+3, `dirty`=0.
- **No false rollover after reset.**
  - Stimulus: reset with `counter_value` held at START; commit.
  - Required: no load until `counter_value` leaves START and returns; then loads occur.
- **Window closes mid-sequence.**
  - Stimulus: 4 dirty channels; `counter_value` leaves START after the 2nd load.
  - Required: the 2 remaining loads happen at R2+1 and R2+2 of the next rollover; `late`=1.
- **Write and commit during busy.**
  - Stimulus: during LOAD, write an already-loaded channel, and raise `commit_req`.
  - Required: that channel stays dirty; a second commit runs automatically on the next rollover and loads the new value.
- **Empty commit.**
  - Stimulus: commit with `dirty`=0.
  - Required: no `duty_load` pulses; `commit_done` at R+1.
- **Reset mid-LOAD.**
  - Stimulus: assert `sysreset` in the cycle after the first load.
  - Required: all outputs take their reset values the next cycle; no further load pulses.
